sr_latch_driver: RTL and testbench
==================================

Name: sr_latch_driver

Overview:
Clocked front-end that feeds the s/r inputs of the sr_latch block. It takes two raw, bouncy request lines (set button, reset button), synchronises and debounces them, and edge-detects them. It then issues clean, fixed-width, mutually exclusive set/reset pulses. The forbidden s=r=1 combination is never driven onto the latch. The block also tracks the latch state it expects and reports request collisions.

Parameters:
DB_CYCLES, 4, consecutive stable synchronised samples needed to accept a new debounced level (range 2..255)
PULSE_W, 2, cycles s or r is held high per issued pulse (range 1..15)
GAP_W, 1, mandatory cycles with s=r=0 after every pulse (range 1..15)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
set_btn  input  1  raw set request, asynchronous to clk, may bounce
rst_btn  input  1  raw reset request, asynchronous to clk, may bounce
s  output  1  set drive to latch, registered
r  output  1  reset drive to latch, registered
busy  output  1  high while the FSM is not in IDLE
conflict  output  1  one-cycle pulse when both requests are pending together and both are dropped
q_exp  output  1  expected latch state after the last completed pulse

Behaviour:
- Reset: asynchronous on rst_n low. Outputs s=0, r=0, busy=0, conflict=0, q_exp=0. Synchronisers, debounce counters, debounced levels, pending flags and FSM all clear; FSM goes to IDLE. If reset asserts mid-pulse, s/r drop immediately, not at the next edge.
- Synchroniser: 2-FF per input. Bench samples raw inputs only through these flops.
- Debounce, per input:
  - The counter counts cycles where the synchronised value differs from db_level.
  - The counter clears whenever the two are equal.
  - When the count reaches DB_CYCLES, db_level takes the synchronised value and the counter clears.
  - Glitches shorter than DB_CYCLES cycles are ignored.
- Edge detect: a db_level 0->1 transition sets the pending flag (set_pend or rst_pend) on the next edge. Falling edges are ignored. A second rise while the same flag is still set merges into it, with no queueing of multiples.
- FSM states: IDLE, SET_P, RST_P, GAP.
  - IDLE, set_pend and rst_pend both 1: pulse conflict for 1 cycle, clear both flags, stay in IDLE.
  - IDLE, only set_pend: go to SET_P, clear set_pend, s=1.
  - IDLE, only rst_pend: go to RST_P, clear rst_pend, r=1.
  - SET_P and RST_P last exactly PULSE_W cycles. On exit, q_exp takes 1 (from SET_P) or 0 (from RST_P), and the FSM goes to GAP with s=r=0.
  - GAP lasts exactly GAP_W cycles, then returns to IDLE.
- Requests during busy: pending flags keep collecting while the FSM is outside IDLE. They are evaluated on the first IDLE cycle, where the conflict rule applies.
- Redundant requests (set while q_exp=1) are still issued. The latch must tolerate them.
- Invariant: s and r are never both 1 in any cycle, including reset entry and exit.
- Latency: raw set_btn rising cleanly and held is first seen at edge E. set_pend rises at edge E+2+DB_CYCLES. s rises at edge E+3+DB_CYCLES. With defaults, s is high for edges 7..8 after E, and busy is high from s rise through the end of GAP.
- Counters are sized for the parameter maxima and never wrap within a pulse or gap.

Test Plan:
1. Reset then clean set: rst_n=0 for 3 cycles, release, hold set_btn=1 → s high for exactly 2 cycles starting DB_CYCLES+3 edges after first sample; r stays 0; q_exp goes 0→1 after the pulse; busy covers 3 cycles.
2. Bounce rejection: toggle set_btn every cycle for 10 cycles, then leave it at 0 → no s pulse, no pending flag, q_exp unchanged.
3. Set then reset sequence: set_btn 1, wait 20 cycles, set_btn 0, rst_btn 1 → one s pulse, then one r pulse of 2 cycles; q_exp goes 1→0; s and r never overlap.
4. Simultaneous requests: set_btn and rst_btn rise on the same edge → conflict high for 1 cycle; s=r=0 throughout; q_exp unchanged; busy stays 0.
5. Request during busy: raise rst_btn while s is high → r pulse starts only after GAP completes, and never in the same cycle as s.
6. Reset mid-pulse: assert rst_n while s=1 → s drops combinationally to 0; q_exp=0; after release, no residual pulse until a new debounced rise occurs.

Source files
------------

// File: rtl/sr_latch_driver_if.sv
// Request/drive bundle between the button front-end and the sr_latch driver.
// The driver block takes the slave view; whoever produces the raw buttons and
// consumes the latch drive takes the master view.
interface sr_latch_driver_if;
  logic set_btn;
  logic rst_btn;
  logic s;
  logic r;
  logic busy;
  logic conflict;
  logic q_exp;

  modport master (
    output set_btn,
    output rst_btn,
    input  s,
    input  r,
    input  busy,
    input  conflict,
    input  q_exp
  );

  modport slave (
    input  set_btn,
    input  rst_btn,
    output s,
    output r,
    output busy,
    output conflict,
    output q_exp
  );
endinterface

// File: rtl/sr_latch_driver.sv
// Clocked front-end for an SR latch: synchronises and debounces two raw
// buttons, turns debounced rising edges into pending requests, and issues
// fixed-width, mutually exclusive s/r pulses followed by a mandatory quiet gap.
// Simultaneous pending requests are dropped and flagged as a conflict.
module sr_latch_driver #(
  parameter int DB_CYCLES = 4,
  parameter int PULSE_W   = 2,
  parameter int GAP_W     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  sr_latch_driver_if.slave  bus
);

  // Channel index 0 carries the set request, index 1 the reset request.
  localparam int CH_SET = 0;
  localparam int CH_RST = 1;

  // Terminal counts; counters are sized for the parameter maxima
  // (DB_CYCLES <= 255, PULSE_W/GAP_W <= 15) so they never wrap.
  localparam logic [7:0] DB_LAST    = 8'(DB_CYCLES - 1);
  localparam logic [3:0] PULSE_LAST = 4'(PULSE_W - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_W - 1);

  // FSM encoding.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SET_P = 2'd1;
  localparam logic [1:0] RST_P = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  logic [1:0]      raw_in;

  logic [1:0]      sync1_q, sync1_d;
  logic [1:0]      sync2_q, sync2_d;

  logic [1:0][7:0] db_cnt_q, db_cnt_d;
  logic [1:0]      db_level_q, db_level_d;
  logic [1:0]      db_prev_q, db_prev_d;
  logic [1:0]      db_rise;

  logic [1:0]      pend_q, pend_d;
  logic [1:0]      pend_clr;

  logic [1:0]      state_q, state_d;
  logic [3:0]      ph_cnt_q, ph_cnt_d;

  logic            s_q, s_d;
  logic            r_q, r_d;
  logic            busy_q, busy_d;
  logic            conflict_q, conflict_d;
  logic            q_exp_q, q_exp_d;

  assign raw_in = {bus.rst_btn, bus.set_btn};

  // Two-flop synchroniser per raw button; raw inputs are never used elsewhere.
  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
  end

  // Debounce: count consecutive cycles where the synchronised input disagrees
  // with the accepted level; accept the new level after DB_CYCLES such cycles.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == db_level_q[i]) begin
        db_cnt_d[i] = 8'd0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_level_d[i] = sync2_q[i];
        db_cnt_d[i]   = 8'd0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 8'd1;
      end
    end
  end

  // Rising-edge detect on the debounced level, one cycle after it changes.
  always_comb begin
    db_prev_d = db_level_q;
    db_rise   = db_level_q & ~db_prev_q;
  end

  // Pending flags: a fresh rise always wins over a same-cycle consume so a
  // request arriving exactly as the previous one is taken is not lost.
  always_comb begin
    pend_d = db_rise | (pend_q & ~pend_clr);
  end

  // Pulse sequencer: IDLE arbitrates pending requests, SET_P/RST_P hold the
  // drive for PULSE_W cycles, GAP forces s=r=0 for GAP_W cycles.
  always_comb begin
    state_d    = state_q;
    ph_cnt_d   = ph_cnt_q;
    q_exp_d    = q_exp_q;
    conflict_d = 1'b0;
    pend_clr   = 2'b00;
    case (state_q)
      IDLE: begin
        ph_cnt_d = 4'd0;
        if (pend_q[CH_SET] && pend_q[CH_RST]) begin
          conflict_d = 1'b1;
          pend_clr   = 2'b11;
        end else if (pend_q[CH_SET]) begin
          state_d          = SET_P;
          pend_clr[CH_SET] = 1'b1;
        end else if (pend_q[CH_RST]) begin
          state_d          = RST_P;
          pend_clr[CH_RST] = 1'b1;
        end
      end
      SET_P, RST_P: begin
        if (ph_cnt_q == PULSE_LAST) begin
          state_d  = GAP;
          ph_cnt_d = 4'd0;
          q_exp_d  = (state_q == SET_P);
        end else begin
          ph_cnt_d = ph_cnt_q + 4'd1;
        end
      end
      GAP: begin
        if (ph_cnt_q == GAP_LAST) begin
          state_d  = IDLE;
          ph_cnt_d = 4'd0;
        end else begin
          ph_cnt_d = ph_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        ph_cnt_d = 4'd0;
      end
    endcase
  end

  // Output drive derived from the next state so s/r are registered and can
  // never both be high: each is a decode of a distinct state.
  always_comb begin
    s_d    = (state_d == SET_P);
    r_d    = (state_d == RST_P);
    busy_d = (state_d != IDLE);
  end

  // State registers; asynchronous reset drops s/r the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 2'b00;
      sync2_q    <= 2'b00;
      db_cnt_q   <= '0;
      db_level_q <= 2'b00;
      db_prev_q  <= 2'b00;
      pend_q     <= 2'b00;
      state_q    <= IDLE;
      ph_cnt_q   <= 4'd0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
      q_exp_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
      db_prev_q  <= db_prev_d;
      pend_q     <= pend_d;
      state_q    <= state_d;
      ph_cnt_q   <= ph_cnt_d;
      s_q        <= s_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
      q_exp_q    <= q_exp_d;
    end
  end

  assign bus.s        = s_q;
  assign bus.r        = r_q;
  assign bus.busy     = busy_q;
  assign bus.conflict = conflict_q;
  assign bus.q_exp    = q_exp_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: a behavioural model predicts every set/reset
// pulse and conflict (kind, start edge, expected latch state) into a queue;
// a monitor pops and compares whenever the DUT raises s, r or conflict.
module tb_sr_latch_driver;

  localparam int DB = 4;
  localparam int PW = 2;
  localparam int GW = 1;

  localparam int K_SET  = 0;
  localparam int K_RST  = 1;
  localparam int K_CONF = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sr_latch_driver_if bus ();

  sr_latch_driver #(
    .DB_CYCLES (DB),
    .PULSE_W   (PW),
    .GAP_W     (GW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int   kind;
    int   start;
    logic q_before;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  conf_seen = 0;
  int  s_seen = 0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Requests are tracked as abstract events: a debounced press becomes a
  // request one edge later; a free driver takes it one edge after that and is
  // then unavailable for PW+GW edges.
  logic m_s1[2], m_s2[2], m_lvl[2], m_pend[2], m_arrive[2];
  int   m_streak[2];
  int   m_free_at;
  logic m_q;

  initial begin : model
    logic raw[2];
    logic take[2];
    ev_t  e;
    forever begin
      @(posedge clk);
      cyc++;
      raw[0] = bus.set_btn;
      raw[1] = bus.rst_btn;
      if (!rst_n) begin
        for (int i = 0; i < 2; i++) begin
          m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0;
          m_pend[i] = 0; m_arrive[i] = 0; m_streak[i] = 0;
        end
        m_free_at = 0;
        m_q = 0;
        exp_q.delete();
      end else begin
        take[0] = 0;
        take[1] = 0;
        if (cyc - 1 >= m_free_at) begin
          if (m_pend[0] && m_pend[1]) begin
            e.kind = K_CONF; e.start = cyc; e.q_before = m_q;
            exp_q.push_back(e);
            take[0] = 1; take[1] = 1;
          end else if (m_pend[0] || m_pend[1]) begin
            e.kind = m_pend[0] ? K_SET : K_RST;
            e.start = cyc; e.q_before = m_q;
            exp_q.push_back(e);
            take[0] = m_pend[0];
            take[1] = !m_pend[0];
            m_free_at = cyc + PW + GW;
            m_q = m_pend[0];
          end
        end
        for (int i = 0; i < 2; i++) begin
          m_pend[i] = m_arrive[i] | (m_pend[i] & !take[i]);
          m_arrive[i] = 0;
          if (m_s2[i] == m_lvl[i]) begin
            m_streak[i] = 0;
          end else begin
            m_streak[i]++;
            if (m_streak[i] == DB) begin
              m_lvl[i] = m_s2[i];
              m_streak[i] = 0;
              m_arrive[i] = m_s2[i];
            end
          end
          m_s2[i] = m_s1[i];
          m_s1[i] = raw[i];
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic cur[3];
    logic prv[3];
    int   hi[3];
    int   need_w;
    ev_t  e;
    for (int i = 0; i < 3; i++) begin prv[i] = 0; hi[i] = 0; end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 3; i++) begin prv[i] = 0; hi[i] = 0; end
      end else begin
        chk(!(bus.s && bus.r), "s_r_overlap", int'(bus.s && bus.r), 0);
        cur[0] = bus.s; cur[1] = bus.r; cur[2] = bus.conflict;
        for (int k = 0; k < 3; k++) begin
          need_w = (k == K_CONF) ? 1 : PW;
          if (cur[k] && !prv[k]) begin
            hi[k] = 1;
            if (k == K_CONF) conf_seen++;
            if (k == K_SET) s_seen++;
            if (exp_q.size() == 0) begin
              chk(0, "unexpected_event_kind", k, -1);
            end else begin
              e = exp_q.pop_front();
              chk(e.kind == k, "event_kind", k, e.kind);
              chk(e.start == cyc, "event_start_edge", cyc, e.start);
              chk(bus.q_exp == e.q_before, "q_exp_at_event", int'(bus.q_exp), int'(e.q_before));
              chk(bus.busy == (k != K_CONF), "busy_at_event", int'(bus.busy), int'(k != K_CONF));
            end
          end else if (cur[k]) begin
            hi[k]++;
          end else if (prv[k]) begin
            chk(hi[k] == need_w, "pulse_width", hi[k], need_w);
            hi[k] = 0;
          end
          prv[k] = cur[k];
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_s_high(input string name);
    for (int k = 0; k < 60 && !bus.s; k++) @(negedge clk);
    chk(bus.s == 1'b1, name, int'(bus.s), 1);
  endtask

  initial begin : stim
    int e0;
    int c0;
    int s0;
    bus.set_btn = 0;
    bus.rst_btn = 0;

    // Reset state
    rst_n = 0;
    tick(3);
    chk(bus.s == 0, "rst_s", int'(bus.s), 0);
    chk(bus.r == 0, "rst_r", int'(bus.r), 0);
    chk(bus.busy == 0, "rst_busy", int'(bus.busy), 0);
    chk(bus.conflict == 0, "rst_conflict", int'(bus.conflict), 0);
    chk(bus.q_exp == 0, "rst_q_exp", int'(bus.q_exp), 0);
    rst_n = 1;
    tick(2);

    // 1: clean set, absolute latency
    bus.set_btn = 1;
    e0 = cyc + 1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      chk(bus.s == (k == 7 || k == 8), "t1_s_timing", int'(bus.s), int'(k == 7 || k == 8));
      chk(bus.r == 0, "t1_r_low", int'(bus.r), 0);
      chk(bus.busy == (k >= 7 && k <= 9), "t1_busy_timing", int'(bus.busy), int'(k >= 7 && k <= 9));
      chk(cyc == e0 + k, "t1_edge_index", cyc, e0 + k);
    end
    chk(bus.q_exp == 1, "t1_q_exp", int'(bus.q_exp), 1);
    bus.set_btn = 0;
    tick(DB + 6);

    // 2: bounce rejection
    s0 = s_seen;
    for (int k = 0; k < 10; k++) begin
      bus.set_btn = ~bus.set_btn;
      tick(1);
    end
    bus.set_btn = 0;
    tick(15);
    chk(s_seen == s0, "t2_no_pulse", s_seen - s0, 0);
    chk(bus.q_exp == 1, "t2_q_exp", int'(bus.q_exp), 1);

    // 3: set then reset
    bus.set_btn = 1;
    tick(20);
    bus.set_btn = 0;
    bus.rst_btn = 1;
    tick(20);
    chk(bus.q_exp == 0, "t3_q_exp", int'(bus.q_exp), 0);
    bus.rst_btn = 0;
    tick(10);

    // 4: simultaneous requests
    c0 = conf_seen;
    bus.set_btn = 1;
    bus.rst_btn = 1;
    for (int k = 0; k < 15; k++) begin
      tick(1);
      chk(bus.busy == 0, "t4_busy_low", int'(bus.busy), 0);
    end
    bus.set_btn = 0;
    bus.rst_btn = 0;
    tick(10);
    chk(conf_seen == c0 + 1, "t4_conflict_count", conf_seen - c0, 1);
    chk(bus.q_exp == 0, "t4_q_exp", int'(bus.q_exp), 0);

    // 5: reset request while s is high
    bus.set_btn = 1;
    wait_s_high("t5_s_timeout");
    bus.rst_btn = 1;
    tick(25);
    chk(bus.q_exp == 0, "t5_q_exp", int'(bus.q_exp), 0);
    bus.set_btn = 0;
    bus.rst_btn = 0;
    tick(10);

    // 6: reset mid-pulse
    bus.set_btn = 1;
    wait_s_high("t6_s_timeout");
    #2;
    rst_n = 0;
    bus.set_btn = 0;
    #1;
    chk(bus.s == 0, "t6_s_async_drop", int'(bus.s), 0);
    chk(bus.r == 0, "t6_r_low", int'(bus.r), 0);
    chk(bus.q_exp == 0, "t6_q_exp", int'(bus.q_exp), 0);
    tick(2);
    rst_n = 1;
    s0 = s_seen;
    tick(20);
    chk(s_seen == s0, "t6_no_residual", s_seen - s0, 0);

    // Randomised presses with short bounce bursts
    for (int it = 0; it < 60; it++) begin
      int nb;
      nb = $urandom_range(0, 3);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 1) == 1) bus.set_btn = ~bus.set_btn;
        else bus.rst_btn = ~bus.rst_btn;
        tick(1);
      end
      bus.set_btn = ($urandom_range(0, 2) == 0);
      bus.rst_btn = ($urandom_range(0, 2) == 0);
      tick($urandom_range(1, 22));
    end

    // Drain
    bus.set_btn = 0;
    bus.rst_btn = 0;
    for (int k = 0; k < 200 && (exp_q.size() != 0 || bus.busy); k++) @(negedge clk);
    tick(DB + 8);
    chk(exp_q.size() == 0, "drain_queue_empty", exp_q.size(), 0);
    chk(bus.busy == 0, "drain_busy", int'(bus.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
